mc_core_param: RTL and testbench

- Parametrised multi-cycle processor core: the next generation of the team's single-cycle-bus processor top.
- Adds a configurable data/address width, one shared memory port with a req/ack wait-state handshake, and a halt/illegal-opcode mechanism.
- Adds a per-instruction retire pulse for verification.
- Control FSM, register file and ALU are all internal; the core sits between a testbench/SoC memory model and nothing else.

---
 rtl/mc_core_param.sv | 230 +++++++++++++++++++++++
 tb/tb_mc_core_param.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core_param.sv
// Parametrised multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT control over a
// single shared req/ack memory port, 32-entry register file and ALU.
module mc_core_param #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              instr_done,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [5:0] OP_R    = 6'h20;
  localparam logic [5:0] OP_ADDI = 6'h30;
  localparam logic [5:0] OP_LI   = 6'h38;
  localparam logic [5:0] OP_LW   = 6'h0F;
  localparam logic [5:0] OP_SW   = 6'h1F;
  localparam logic [5:0] OP_BEQ  = 6'h00;
  localparam logic [5:0] OP_B    = 6'h3F;
  localparam logic [5:0] OP_HALT = 6'h3E;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         pc_q, pc_d;
  logic [31:0]               ir_q, ir_d;
  logic signed [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic signed [DATA_W-1:0]  res_q, res_d;
  logic                      illegal_q, illegal_d;
  logic [DATA_W-1:0]         rf_q [32];

  logic                      rf_we;
  logic                      mem_req_c, mem_we_c;
  logic [ADDR_W-1:0]         mem_addr_c;
  logic [DATA_W-1:0]         mem_wdata_c;

  function automatic logic signed [DATA_W-1:0] sext_data(input logic [15:0] v);
    logic [DATA_W+15:0] t;
    t = {{DATA_W{v[15]}}, v};
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] sext_addr(input logic [15:0] v);
    logic [ADDR_W+15:0] t;
    t = {{ADDR_W{v[15]}}, v};
    return t[ADDR_W-1:0];
  endfunction

  // Effective addresses are the low ADDR_W bits of the data-width sum.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    logic [ADDR_W+DATA_W-1:0] t;
    t = {{ADDR_W{1'b0}}, v};
    return t[ADDR_W-1:0];
  endfunction

  function automatic logic op_legal(input logic [5:0] op, input logic [3:0] fn);
    case (op)
      OP_R:                               return (fn <= 4'd5);
      OP_ADDI, OP_LI, OP_LW, OP_SW,
      OP_BEQ, OP_B, OP_HALT:              return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] alu(
    input logic [5:0]               op,
    input logic [3:0]               fn,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] imm
  );
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_R: begin
        case (fn)
          4'd0:    r = a + b;
          4'd1:    r = a - b;
          4'd2:    r = a & b;
          4'd3:    r = a | b;
          4'd4:    r = a ^ b;
          4'd5:    r[0] = (a < b);
          default: r = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: r = a + imm;
      OP_LI:                 r = imm;
      default:               r = '0;
    endcase
    return r;
  endfunction

  logic [5:0]               op;
  logic [4:0]               rs, rd, rt;
  logic [3:0]               fn;
  logic [15:0]              imm;
  logic signed [DATA_W-1:0] imm_x;
  logic [ADDR_W-1:0]        br_off;
  logic [DATA_W-1:0]        rs_val, rd_val, rt_val;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rd     = ir_q[20:16];
  assign rt     = ir_q[15:11];
  assign fn     = ir_q[3:0];
  assign imm    = ir_q[15:0];
  assign imm_x  = sext_data(imm);
  assign br_off = sext_addr(imm) << 2;
  assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rd_val = (rd == 5'd0) ? '0 : rf_q[rd];
  assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    illegal_d   = illegal_q;
    rf_we       = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        mem_addr_c = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata[31:0];
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs_val;
        b_d = (op == OP_R) ? rt_val : rd_val;
        if (op == OP_HALT) begin
          state_d    = S_HALT;
          instr_done = 1'b1;
        end else if (!op_legal(op, fn)) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = alu(op, fn, a_q, b_q, imm_x);
        if (op == OP_B || op == OP_BEQ) begin
          // PC already points past the branch, so the target is PC + offset.
          if (op == OP_B || a_q == b_q) pc_d = pc_q + br_off;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c   = 1'b1;
        mem_we_c    = (op == OP_SW);
        mem_addr_c  = to_addr(res_q);
        mem_wdata_c = (op == OP_SW) ? b_q : '0;
        if (mem_ack) begin
          if (op == OP_SW) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            res_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we      = (rd != 5'd0);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
      if (rf_we) rf_q[rd] <= res_q;
    end
  end

  // Reset gates the port combinationally so an in-flight request drops at once.
  assign mem_req   = mem_req_c & ~reset;
  assign mem_we    = mem_we_c & ~reset;
  assign mem_addr  = reset ? '0 : mem_addr_c;
  assign mem_wdata = reset ? '0 : mem_wdata_c;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_mc_core_param.sv
// Directed bench for mc_core_param: 32-bit core on a wait-state memory model,
// plus a 64-bit/16-bit-address build running a small wrap-around program.
module tb_mc_core_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset64 = 1'b1;
  always #5 clk = ~clk;

  logic        mem_req, mem_we, mem_ack, instr_done, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  mc_core_param #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .instr_done(instr_done), .halted(halted),
    .illegal(illegal), .pc_out(pc_out)
  );

  logic        m64_req, m64_we, m64_done, m64_halted, m64_illegal;
  logic [15:0] m64_addr, m64_pc;
  logic [63:0] m64_wdata, m64_rdata;

  mc_core_param #(.DATA_W(64), .ADDR_W(16), .RESET_PC(16'h0040)) dut64 (
    .clk(clk), .reset(reset64), .mem_req(m64_req), .mem_we(m64_we),
    .mem_addr(m64_addr), .mem_wdata(m64_wdata), .mem_rdata(m64_rdata),
    .mem_ack(m64_req), .instr_done(m64_done), .halted(m64_halted),
    .illegal(m64_illegal), .pc_out(m64_pc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rd, input logic [15:0] imm);
    return {op, rs, rd, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rd,
                                     input logic [4:0] rt, input logic [3:0] fn);
    return {6'h20, rs, rd, rt, 7'd0, fn};
  endfunction

  localparam logic [31:0] HALT = 32'hF800_0000;

  // 32-bit memory model: ack after ws wait cycles, reloaded from prog in reset.
  logic [31:0] prog [256];
  logic [31:0] mem  [256];
  int          ws = 0;
  int          wcnt;
  int          wr_cnt;
  logic [31:0] wr_addr0, wr_data0;

  assign mem_ack   = mem_req && (wcnt >= ws);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      wcnt   <= 0;
      wr_cnt <= 0;
    end else if (mem_req && mem_ack) begin
      wcnt <= 0;
      if (mem_we) begin
        mem[mem_addr[9:2]] <= mem_wdata;
        if (wr_cnt == 0) begin
          wr_addr0 <= mem_addr;
          wr_data0 <= mem_wdata;
        end
        wr_cnt <= wr_cnt + 1;
      end
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  // Observation counters, cleared while reset is held.
  int          cyc, run_cyc, n_done, halt_req, stab_err;
  int          done_t [64];
  logic        p_req, p_ack, p_we;
  logic [31:0] p_addr, p_wdata;

  always @(negedge clk) begin
    if (reset) begin
      cyc <= 0; run_cyc <= 0; n_done <= 0; halt_req <= 0; stab_err <= 0;
      p_req <= 1'b0; p_ack <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!halted) run_cyc <= run_cyc + 1;
      if (instr_done) begin
        if (n_done < 64) done_t[n_done] <= cyc + 1;
        n_done <= n_done + 1;
      end
      if (halted && mem_req) halt_req <= halt_req + 1;
      if (p_req && !p_ack && (!mem_req || mem_addr != p_addr || mem_we != p_we ||
                              mem_wdata != p_wdata))
        stab_err <= stab_err + 1;
      p_req <= mem_req; p_ack <= mem_ack; p_we <= mem_we;
      p_addr <= mem_addr; p_wdata <= mem_wdata;
    end
  end

  // 64-bit build: zero-wait ROM at 0x40 and a write log.
  int          w64_n;
  logic [63:0] w64_d0, w64_d1;
  always_comb begin
    m64_rdata = '0;
    case (m64_addr[7:0])
      8'h40: m64_rdata = {32'h0, ei(6'h38, 5'd0, 5'd1, 16'hFFFF)};
      8'h44: m64_rdata = {32'h0, ei(6'h30, 5'd1, 5'd2, 16'h0001)};
      8'h48: m64_rdata = {32'h0, ei(6'h1F, 5'd0, 5'd1, 16'h0100)};
      8'h4C: m64_rdata = {32'h0, ei(6'h1F, 5'd0, 5'd2, 16'h0108)};
      8'h50: m64_rdata = {32'h0, HALT};
      default: m64_rdata = '0;
    endcase
  end
  always @(posedge clk) begin
    if (reset64) w64_n <= 0;
    else if (m64_req && m64_we) begin
      if (w64_n == 0) w64_d0 <= m64_wdata;
      if (w64_n == 1) w64_d1 <= m64_wdata;
      w64_n <= w64_n + 1;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic hold_reset(input int w);
    reset = 1'b1;
    ws    = w;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic go(input string tag, input int budget);
    int i;
    reset = 1'b0;
    i = 0;
    while (!halted && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk({tag, "_halted"}, halted, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic found;

    // ---- basic program, zero wait ----
    clear_prog();
    prog[0] = ei(6'h38, 5'd0, 5'd1, 16'd5);
    prog[1] = ei(6'h38, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = er(5'd1, 5'd3, 5'd2, 4'd0);
    prog[3] = ei(6'h1F, 5'd0, 5'd3, 16'h0200);
    prog[4] = HALT;
    hold_reset(0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_done", instr_done, 1'b0);
    reset64 = 1'b0;
    chk("r64_pc", m64_pc, 16'h0040);
    go("basic", 200);
    chk("basic_r3", mem[8'h80], 32'd2);
    chk("basic_cycles", run_cyc, 18);
    chk("basic_ndone", n_done, 5);
    chk("basic_first_done", done_t[0], 4);
    chk("basic_illegal", illegal, 1'b0);
    chk("basic_pc", pc_out, 32'h14);
    chk("basic_halt_req", halt_req, 0);

    // ---- same program, 3 wait states per transfer ----
    hold_reset(3);
    go("wait", 400);
    chk("wait_r3", mem[8'h80], 32'd2);
    chk("wait_cycles", run_cyc, 36);
    chk("wait_ndone", n_done, 5);
    chk("wait_stable", stab_err, 0);

    // ---- ALU operations ----
    clear_prog();
    prog[0]  = ei(6'h38, 5'd0, 5'd1, 16'd5);
    prog[1]  = ei(6'h38, 5'd0, 5'd2, 16'hFFFD);
    prog[2]  = er(5'd1, 5'd3, 5'd2, 4'd1);
    prog[3]  = er(5'd1, 5'd4, 5'd2, 4'd2);
    prog[4]  = er(5'd1, 5'd5, 5'd2, 4'd3);
    prog[5]  = er(5'd1, 5'd6, 5'd2, 4'd4);
    prog[6]  = er(5'd2, 5'd7, 5'd1, 4'd5);
    prog[7]  = er(5'd1, 5'd8, 5'd2, 4'd5);
    prog[8]  = ei(6'h30, 5'd1, 5'd9, 16'hFFF9);
    for (int r = 3; r <= 9; r++) prog[9 + r - 3] = ei(6'h1F, 5'd0, 5'(r), 16'(32'h200 + (r - 3) * 4));
    prog[16] = HALT;
    hold_reset(0);
    go("alu", 400);
    chk("alu_sub", mem[8'h80], 32'd8);
    chk("alu_and", mem[8'h81], 32'd5);
    chk("alu_or",  mem[8'h82], 32'hFFFF_FFFD);
    chk("alu_xor", mem[8'h83], 32'hFFFF_FFF8);
    chk("alu_slt_t", mem[8'h84], 32'd1);
    chk("alu_slt_f", mem[8'h85], 32'd0);
    chk("alu_addi", mem[8'h86], 32'hFFFF_FFFE);

    // ---- store then load ----
    clear_prog();
    prog[8'h60] = 32'hDEAD_BEEF;
    prog[0] = ei(6'h0F, 5'd0, 5'd1, 16'h0180);
    prog[1] = ei(6'h1F, 5'd0, 5'd1, 16'h0100);
    prog[2] = ei(6'h0F, 5'd0, 5'd4, 16'h0100);
    prog[3] = ei(6'h1F, 5'd0, 5'd4, 16'h0104);
    prog[4] = HALT;
    hold_reset(0);
    go("ldst", 200);
    chk("ldst_wr_addr", wr_addr0, 32'h100);
    chk("ldst_wr_data", wr_data0, 32'hDEAD_BEEF);
    chk("ldst_wr_cnt", wr_cnt, 2);
    chk("ldst_r4", mem[8'h41], 32'hDEAD_BEEF);
    chk("ldst_lw_lat", done_t[0], 5);
    chk("ldst_lw2_lat", done_t[2] - done_t[1], 5);
    chk("ldst_cycles", run_cyc, 20);

    // ---- branches ----
    clear_prog();
    prog[0] = ei(6'h38, 5'd0, 5'd1, 16'd3);
    prog[1] = ei(6'h38, 5'd0, 5'd2, 16'd0);
    prog[2] = ei(6'h00, 5'd2, 5'd1, 16'd2);
    prog[3] = ei(6'h30, 5'd2, 5'd2, 16'd1);
    prog[4] = ei(6'h00, 5'd1, 5'd1, 16'hFFFD);
    prog[5] = ei(6'h1F, 5'd0, 5'd2, 16'h0200);
    prog[6] = ei(6'h3F, 5'd0, 5'd0, 16'd1);
    prog[7] = ei(6'h38, 5'd0, 5'd5, 16'd99);
    prog[8] = ei(6'h1F, 5'd0, 5'd5, 16'h0204);
    prog[9] = HALT;
    hold_reset(0);
    go("br", 400);
    chk("br_count", mem[8'h80], 32'd3);
    chk("br_skip", mem[8'h81], 32'd0);
    chk("br_cycles", run_cyc, 54);
    chk("br_ndone", n_done, 16);
    chk("br_nt_done", done_t[2], 11);
    chk("br_tk_done", done_t[4], 18);
    chk("br_pc", pc_out, 32'h28);

    // ---- undefined opcode ----
    clear_prog();
    prog[0] = ei(6'h38, 5'd0, 5'd1, 16'd1);
    prog[1] = 32'h5400_0000;
    prog[2] = ei(6'h1F, 5'd0, 5'd1, 16'h0200);
    prog[3] = HALT;
    hold_reset(0);
    go("ill", 200);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_ndone", n_done, 1);
    chk("ill_writes", wr_cnt, 0);
    chk("ill_halt_req", halt_req, 0);
    chk("ill_cycles", run_cyc, 6);
    chk("ill_pc", pc_out, 32'h8);

    // ---- undefined R-type func ----
    clear_prog();
    prog[0] = er(5'd1, 5'd3, 5'd2, 4'd6);
    hold_reset(0);
    chk("illf_rst_clear", illegal, 1'b0);
    go("illf", 200);
    chk("illf_flag", illegal, 1'b1);
    chk("illf_ndone", n_done, 0);

    // ---- r0 is hard-wired zero ----
    clear_prog();
    prog[8'h80] = 32'hFFFF_FFFF;
    prog[8'h81] = 32'hFFFF_FFFF;
    prog[0] = ei(6'h38, 5'd0, 5'd0, 16'd7);
    prog[1] = er(5'd0, 5'd5, 5'd0, 4'd0);
    prog[2] = ei(6'h1F, 5'd0, 5'd5, 16'h0200);
    prog[3] = ei(6'h1F, 5'd0, 5'd0, 16'h0204);
    prog[4] = HALT;
    hold_reset(0);
    go("r0", 200);
    chk("r0_r5", mem[8'h80], 32'd0);
    chk("r0_r0", mem[8'h81], 32'd0);
    chk("r0_illegal", illegal, 1'b0);

    // ---- reset during a stalled store ----
    clear_prog();
    prog[0] = ei(6'h38, 5'd0, 5'd1, 16'd5);
    prog[1] = ei(6'h1F, 5'd0, 5'd1, 16'h0200);
    prog[2] = HALT;
    hold_reset(10);
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1'b1;
    end
    chk("mrst_found_store", found, 1'b1);
    #2 reset = 1'b1;
    ws = 0;
    #1;
    chk("mrst_req", mem_req, 1'b0);
    chk("mrst_we", mem_we, 1'b0);
    chk("mrst_pc", pc_out, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_refetch_req", mem_req, 1'b1);
    chk("mrst_refetch_addr", mem_addr, 32'h0);
    chk("mrst_refetch_we", mem_we, 1'b0);
    go("mrst", 200);
    chk("mrst_store", mem[8'h80], 32'd5);

    // ---- 64-bit build results ----
    chk("w64_halted", m64_halted, 1'b1);
    chk("w64_illegal", m64_illegal, 1'b0);
    chk("w64_nwr", w64_n, 2);
    chk("w64_ones", w64_d0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_wrap", w64_d1, 64'h0);
    chk("w64_pc", m64_pc, 16'h0054);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
